// File: rtl/host_cmd_pkg.sv
// Shared constants and FSM state type for the host command controller.
package host_cmd_pkg;

  localparam logic [7:0] CMD_RESET      = 8'hFF;
  localparam logic [7:0] CMD_START_BASE = 8'hF0;

  localparam logic [7:0] RSP_START_BASE = 8'hA0;
  localparam logic [7:0] RSP_STOPPED    = 8'hAF;
  localparam logic [7:0] RSP_FORCED     = 8'hAE;
  localparam logic [7:0] RSP_NAK        = 8'h15;
  localparam logic [7:0] RSP_TIMEOUT    = 8'hE2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

endpackage

// File: rtl/rsp_fifo.sv
// Response byte FIFO: never back-pressures the writer, drops on overflow and
// latches a sticky overflow flag until reset.
module rsp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       rdy_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wrPtr_q, rdPtr_q;
  logic        ovf_q;
  logic        empty, full, pop, doPush;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop    = !empty && rdy_i;
  assign doPush = push_i && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (pop)    rdPtr_q <= rdPtr_q + (AW+1)'(1);
      if (push_i && !doPush) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = empty ? 8'h00 : mem[rdPtr_q[AW-1:0]];
  assign valid_o = !empty;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/host_cmd_ctrl.sv
// Host command controller: decodes START/RESET bytes, drives one channel enable
// and queues a status byte per command. Optional stop timeout: HOST_CMD_TIMEOUT_EN.
module host_cmd_ctrl
  import host_cmd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TMO_W     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_d,
  input  logic              rx_rdy,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_enable,
  output logic              busy,
  output logic [7:0]        rsp_d,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_ovf
);

  if (NUM_CH < 1 || NUM_CH > 8 || RSP_DEPTH < 2 || TMO_W < 1) begin : g_param_check
    $error("host_cmd_ctrl: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [2:0]  activeCh_q, activeCh_d;
  logic [NUM_CH-1:0] chMask;
  logic        isReset, isStart, startOk, doneAct, tmoHit;
  logic        push;
  logic [7:0]  pushData;

  assign isReset = rx_rdy && (rx_d == CMD_RESET);
  assign isStart = rx_rdy && (rx_d[7:3] == CMD_START_BASE[7:3]);
  assign startOk = 32'(rx_d[2:0]) < NUM_CH;
  assign chMask  = NUM_CH'(1) << activeCh_q;
  assign doneAct = |(ch_done & chMask);

`ifdef HOST_CMD_TIMEOUT_EN
  logic [TMO_W-1:0] tmoCnt_q;

  // Counter sits at zero outside PEND, so it starts fresh on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tmoCnt_q <= '0;
    else if (state_q != PEND)  tmoCnt_q <= '0;
    else                       tmoCnt_q <= tmoCnt_q + TMO_W'(1);
  end

  assign tmoHit = (state_q == PEND) && (tmoCnt_q == '1);
`else
  assign tmoHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      activeCh_q <= '0;
    end else begin
      state_q    <= state_d;
      activeCh_q <= activeCh_d;
    end
  end

  // At most one response per cycle; in PEND done beats RESET beats timeout.
  always_comb begin
    state_d    = state_q;
    activeCh_d = activeCh_q;
    push       = 1'b0;
    pushData   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (isReset) begin
          push     = 1'b1;
          pushData = RSP_STOPPED;
        end else if (isStart) begin
          push = 1'b1;
          if (startOk) begin
            state_d    = RUN;
            activeCh_d = rx_d[2:0];
            pushData   = RSP_START_BASE | {5'd0, rx_d[2:0]};
          end else begin
            pushData = RSP_NAK;
          end
        end
      end
      RUN: begin
        if (isStart) begin
          push     = 1'b1;
          pushData = RSP_NAK;
        end else if (isReset) begin
          if (doneAct) begin
            state_d  = IDLE;
            push     = 1'b1;
            pushData = RSP_STOPPED;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (doneAct) begin
          state_d  = IDLE;
          push     = 1'b1;
          pushData = RSP_STOPPED;
        end else if (isReset) begin
          state_d  = IDLE;
          push     = 1'b1;
          pushData = RSP_FORCED;
        end else if (tmoHit) begin
          state_d  = IDLE;
          push     = 1'b1;
          pushData = RSP_TIMEOUT;
        end else if (isStart) begin
          push     = 1'b1;
          pushData = RSP_NAK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign ch_enable = busy ? chMask : '0;

  rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (pushData),
    .rdy_i   (rsp_ready),
    .data_o  (rsp_d),
    .valid_o (rsp_valid),
    .ovf_o   (rsp_ovf)
  );

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Self-checking bench for host_cmd_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_host_cmd_ctrl;

  localparam int NUM_CH    = 4;
  localparam int RSP_DEPTH = 4;
`ifdef HOST_CMD_TIMEOUT_EN
  localparam int TMO_W = 4;
`else
  localparam int TMO_W = 24;
`endif

  logic              clk;
  logic              reset_n;
  logic [7:0]        rx_d;
  logic              rx_rdy;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_enable;
  logic              busy;
  logic [7:0]        rsp_d;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_ovf;

  int checks = 0;
  int errors = 0;

  host_cmd_ctrl #(.NUM_CH(NUM_CH), .RSP_DEPTH(RSP_DEPTH), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_d      (rx_d),
    .rx_rdy    (rx_rdy),
    .ch_done   (ch_done),
    .ch_enable (ch_enable),
    .busy      (busy),
    .rsp_d     (rsp_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: running/stopping flags, the channel in use, and the
  // exact byte sequence the serializer should see.
  logic [7:0] expQ[$];
  bit         mRunning, mStopping, mOvf;
  int         mCh, mPendCycles;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_d   = b;
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
  endtask

  task automatic drainOne();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit         haveRsp;
    logic [7:0] rsp;
    bit         doneNow, isRst, isSt;
    int         n;
    if (!reset_n) begin
      expQ.delete();
      mRunning    = 0;
      mStopping   = 0;
      mOvf        = 0;
      mCh         = 0;
      mPendCycles = 0;
    end else begin
      haveRsp = 0;
      rsp     = 8'h00;
      isRst   = rx_rdy && rx_d == 8'hFF;
      isSt    = rx_rdy && rx_d >= 8'hF0 && rx_d <= 8'hF7;
      n       = int'(rx_d) - 'hF0;
      doneNow = ch_done[mCh];
      if (!mRunning) begin
        if (isRst) begin haveRsp = 1; rsp = 8'hAF; end
        else if (isSt) begin
          haveRsp = 1;
          if (n < NUM_CH) begin mRunning = 1; mCh = n; rsp = 8'hA0 + 8'(n); end
          else rsp = 8'h15;
        end
      end else if (!mStopping) begin
        if (isSt) begin haveRsp = 1; rsp = 8'h15; end
        else if (isRst) begin
          if (doneNow) begin mRunning = 0; haveRsp = 1; rsp = 8'hAF; end
          else begin mStopping = 1; mPendCycles = 0; end
        end
      end else begin
        if (doneNow) begin mRunning = 0; mStopping = 0; haveRsp = 1; rsp = 8'hAF; end
        else if (isRst) begin mRunning = 0; mStopping = 0; haveRsp = 1; rsp = 8'hAE; end
`ifdef HOST_CMD_TIMEOUT_EN
        else if (mPendCycles == (2**TMO_W) - 1) begin
          mRunning = 0; mStopping = 0; haveRsp = 1; rsp = 8'hE2;
        end
`endif
        else begin
          if (isSt) begin haveRsp = 1; rsp = 8'h15; end
          mPendCycles++;
        end
      end
      if (expQ.size() > 0 && rsp_ready) void'(expQ.pop_front());
      if (haveRsp) begin
        if (expQ.size() < RSP_DEPTH) expQ.push_back(rsp);
        else mOvf = 1;
      end
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] expEn;
    expEn = mRunning ? NUM_CH'(1 << mCh) : '0;
    checkOutput("model ch_enable", 32'(ch_enable), 32'(expEn));
    checkOutput("model busy", 32'(busy), 32'(mRunning));
    checkOutput("model rsp_valid", 32'(rsp_valid), 32'(expQ.size() > 0));
    if (expQ.size() > 0) checkOutput("model rsp_d", 32'(rsp_d), 32'(expQ[0]));
    checkOutput("model rsp_ovf", 32'(rsp_ovf), 32'(mOvf));
  end

  initial begin
    int pick;
    reset_n   = 1'b0;
    rx_d      = 8'h00;
    rx_rdy    = 1'b0;
    ch_done   = '0;
    rsp_ready = 1'b0;
    #2;
    checkOutput("reset ch_enable", 32'(ch_enable), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset rsp_d", 32'(rsp_d), 32'h00);
    checkOutput("reset rsp_ovf", 32'(rsp_ovf), 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] start channel 2");
    applyStimulus(8'hF2);
    checkOutput("start2 ch_enable", 32'(ch_enable), 32'h4);
    checkOutput("start2 busy", 32'(busy), 32'h1);
    checkOutput("start2 rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("start2 rsp_d", 32'(rsp_d), 32'hA2);
    drainOne();
    checkOutput("start2 drained", 32'(rsp_valid), 32'h0);

    $display("[TB] graceful stop via done");
    applyStimulus(8'hFF);
    checkOutput("pend busy", 32'(busy), 32'h1);
    checkOutput("pend no rsp", 32'(rsp_valid), 32'h0);
    checkOutput("pend ch_enable", 32'(ch_enable), 32'h4);
    ch_done = 4'b0100;
    tick();
    ch_done = '0;
    checkOutput("done ch_enable", 32'(ch_enable), 32'h0);
    checkOutput("done busy", 32'(busy), 32'h0);
    checkOutput("done rsp_d", 32'(rsp_d), 32'hAF);
    drainOne();

    $display("[TB] forced stop");
    applyStimulus(8'hF1);
    drainOne();
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    checkOutput("forced busy", 32'(busy), 32'h0);
    checkOutput("forced rsp_d", 32'(rsp_d), 32'hAE);
    drainOne();
    checkOutput("forced single rsp", 32'(rsp_valid), 32'h0);

    $display("[TB] NAK cases and payload");
    applyStimulus(8'hF7);
    checkOutput("bad ch rsp_d", 32'(rsp_d), 32'h15);
    checkOutput("bad ch enable", 32'(ch_enable), 32'h0);
    drainOne();
    applyStimulus(8'hF3);
    drainOne();
    applyStimulus(8'hF1);
    checkOutput("run start rsp_d", 32'(rsp_d), 32'h15);
    checkOutput("run start enable", 32'(ch_enable), 32'h8);
    drainOne();
    ch_done = 4'b1000;
    applyStimulus(8'hFF);
    ch_done = '0;
    checkOutput("run done stop rsp_d", 32'(rsp_d), 32'hAF);
    checkOutput("run done stop busy", 32'(busy), 32'h0);
    drainOne();
    applyStimulus(8'h42);
    checkOutput("payload ignored", 32'(rsp_valid), 32'h0);

    $display("[TB] overflow and async reset");
    for (int i = 0; i < 5; i++) applyStimulus(8'hFF);
    checkOutput("ovf flag", 32'(rsp_ovf), 32'h1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("ovf drain rsp_d", 32'(rsp_d), 32'hAF);
      drainOne();
    end
    checkOutput("ovf still valid", 32'(rsp_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("async rst rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("async rst rsp_ovf", 32'(rsp_ovf), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] pending stop timeout behaviour");
    applyStimulus(8'hF0);
    drainOne();
    applyStimulus(8'hFF);
    repeat (20) tick();
`ifdef HOST_CMD_TIMEOUT_EN
    checkOutput("tmo busy", 32'(busy), 32'h0);
    checkOutput("tmo rsp_d", 32'(rsp_d), 32'hE2);
`else
    checkOutput("no tmo busy", 32'(busy), 32'h1);
    checkOutput("no tmo rsp_valid", 32'(rsp_valid), 32'h0);
    ch_done = 4'b0001;
    tick();
    ch_done = '0;
    checkOutput("late done rsp_d", 32'(rsp_d), 32'hAF);
`endif
    drainOne();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      rx_rdy = 1'($urandom_range(0, 1));
      pick   = int'($urandom_range(0, 9));
      if (pick < 3)      rx_d = 8'hFF;
      else if (pick < 7) rx_d = 8'hF0 + 8'($urandom_range(0, 7));
      else               rx_d = 8'($urandom);
      ch_done   = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rx_rdy    = 1'b0;
    ch_done   = '0;
    rsp_ready = 1'b1;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_cmd_ctrl.md
# host_cmd_ctrl

Host command controller for the UART link: decodes command bytes from the RX path, starts/stops one of `NUM_CH` test channels, and runs the graceful-then-forced reset handshake. Each command produces a status byte, queued for the TX byte serializer. Runs entirely in the `clk` domain on the `rx_rdy` strobe, with no derived UART clock. It generalises the single-channel test enable logic to N channels and adds acknowledgements and an optional stop timeout.

## Interface
- `NUM_CH`, 4, number of test channels, 1..8
- `RSP_DEPTH`, 4, response FIFO depth, power of two, ≥2
- `TMO_W`, 24, width of the pending-stop timeout counter
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `rx_d`  in  8  received byte, valid while `rx_rdy`=1
- `rx_rdy`  in  1  one-cycle strobe per received byte
- `ch_done`  in  NUM_CH  per-channel done level from the test engines
- `ch_enable`  out  NUM_CH  one-hot (or zero) run enable
- `busy`  out  1  state ≠ IDLE
- `rsp_d`  out  8  status byte to the serializer
- `rsp_valid`  out  1  `rsp_d` valid
- `rsp_ready`  in  1  serializer accepts `rsp_d`
- `rsp_ovf`  out  1  sticky flag: a response was dropped because the FIFO was full

## Operation
- Commands:
  - `0xFF`: RESET.
  - `0xF0+n`, for n < NUM_CH: START channel n.
  - `0xF0+n`, for n ≥ NUM_CH up to `0xF7`: START to a bad channel.
  - All other bytes are channel payload and are ignored here, with no response.
- FSM states:
  - IDLE:
    - START n: go to RUN, `active_ch`=n, respond `0xA0|n`.
    - START to a bad channel: respond `0x15` (NAK).
    - RESET: respond `0xAF`.
  - RUN:
    - START: respond `0x15` and stay in RUN.
    - RESET with `ch_done[active_ch]`=1: go to IDLE, respond `0xAF`.
    - RESET with `ch_done[active_ch]`=0: go to PEND, no response.
  - PEND:
    - `ch_done[active_ch]`=1: go to IDLE, respond `0xAF`.
    - Second RESET: forced stop, go to IDLE, respond `0xAE`.
    - START: respond `0x15`.
    - If a RESET and done arrive in the same cycle, done wins: respond `0xAF` only.
- `ch_enable[active_ch]`=1 in RUN and PEND; all bits are 0 in IDLE.
- Done bits of non-active channels are ignored.
- Response FIFO:
  - A push when full drops the byte and sets `rsp_ovf`.
  - The FSM never stalls on a full FIFO.
  - `rsp_ovf` clears only on reset.
  - A push and a pop in the same cycle when full both succeed.

## Timing
- Reset values:
  - `ch_enable`=0, `busy`=0, `rsp_valid`=0, `rsp_d`=0x00, `rsp_ovf`=0.
  - State IDLE, FIFO empty.
- Reset asserted mid-operation clears everything asynchronously. No response is emitted for it.
- Latency:
  - `rx_rdy` in cycle t → state, `ch_enable` and `busy` update at edge t+1.
  - The response is pushed at edge t+1. `rsp_valid` is high from t+1 when the FIFO was empty.
- The done-driven exit from PEND follows the same rule: `ch_done` seen at t → IDLE at t+1.
- Handshake: a byte transfers on any edge with `rsp_valid && rsp_ready`. `rsp_d` is stable while `rsp_valid && !rsp_ready`.
- `rx_rdy` may be asserted on back-to-back cycles; every byte is processed.

## Configuration
- `HOST_CMD_TIMEOUT_EN`:
  - Defined: a `TMO_W`-bit counter clears on entry to PEND and increments each cycle in PEND. On reaching all-ones it forces IDLE and responds `0xE2`. Done or a second RESET in the same cycle takes priority.
  - Undefined: no counter; PEND waits indefinitely for done or a second RESET.

## Structure
- Package `host_cmd_pkg` holds:
  - command constants (`CMD_RESET`, `CMD_START_BASE`);
  - response codes (`RSP_START_BASE`, `RSP_STOPPED`, `RSP_FORCED`, `RSP_NAK`, `RSP_TIMEOUT`);
  - the FSM state enum (IDLE, RUN, PEND).
- Sub-module `rsp_fifo`: synchronous FIFO of `RSP_DEPTH`×8 with a push/overflow-drop interface. Uses pointers one bit wider than the address for full/empty detection.

## Test plan
- Reset, then `0xF2` → `ch_enable`=4'b0100 one cycle later, response `0xA2`, `busy`=1.
- In RUN on channel 2 with `ch_done[2]`=0, send `0xFF` → state PEND, no response. Then raise `ch_done[2]` → `ch_enable`=0 next cycle, response `0xAF`.
- In RUN, send `0xFF`, `0xFF` on consecutive strobes with done low → IDLE after the second strobe, single response `0xAE`.
- In IDLE, send `0xF7` with NUM_CH=4 → `0x15` and no enable. In RUN, send `0xF1` → `0x15` and channel unchanged.
- Hold `rsp_ready`=0 and issue 5 IDLE resets with RSP_DEPTH=4 → 4 × `0xAF` drained in order and `rsp_ovf`=1. Asserting `reset_n`=0 mid-drain clears `rsp_valid` asynchronously.
- With `HOST_CMD_TIMEOUT_EN` and `TMO_W`=4: enter PEND with done low → response `0xE2` and IDLE once the counter hits all-ones. A build without the macro stays in PEND.
